booth8_seq_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/booth8_digit_enc.sv | 30 +++
 rtl/booth8_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_booth8_seq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the radix-8 Booth multipliers: controller states,
// partial-product magnitude selects and the Booth group count.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, PRE, ACC, DONE} state_t;

  typedef enum logic [2:0] {SEL_0, SEL_1M, SEL_2M, SEL_3M, SEL_4M} sel_t;

  function automatic int ngrp_f(input int bits);
    return (bits + 3) / 3;
  endfunction

endpackage

// File: rtl/booth8_digit_enc.sv
// Radix-8 Booth digit encoder: 4-bit overlapping multiplier group to
// magnitude select (0..4M) plus sign.
module booth8_digit_enc
  import mult_pkg::*;
(
  input  logic [3:0] grp_i,
  output sel_t       sel_o,
  output logic       neg_o
);

  logic [2:0] pos_sum;
  logic [2:0] mag;

  // Digit = -4*g[3] + pos_sum; for negative digits the magnitude is 4 - pos_sum.
  assign pos_sum = {1'b0, grp_i[2], 1'b0} + {2'b00, grp_i[1]} + {2'b00, grp_i[0]};
  assign neg_o   = grp_i[3];
  assign mag     = grp_i[3] ? (3'd4 - pos_sum) : pos_sum;

  always_comb begin
    sel_o = SEL_0;
    case (mag)
      3'd1:    sel_o = SEL_1M;
      3'd2:    sel_o = SEL_2M;
      3'd3:    sel_o = SEL_3M;
      3'd4:    sel_o = SEL_4M;
      default: sel_o = SEL_0;
    endcase
  end

endmodule

// File: rtl/booth8_seq_ctrl.sv
// Sequential radix-8 Booth multiplier: one Booth group per clock, 3M
// precomputed once per operation, valid/ready on both sides.
module booth8_seq_ctrl
  import mult_pkg::*;
#(
  parameter int Bits = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [Bits-1:0]   iM,
  input  logic [Bits-1:0]   iQ,
  output logic              oValid,
  input  logic              iReady,
  output logic [2*Bits-1:0] oZ,
  output logic              oBusy
);

  localparam int NGRP = ngrp_f(Bits);
  localparam int KW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int MW   = Bits + 2;
  localparam int AW   = 2 * Bits + 3;
  localparam int QW   = 3 * NGRP + 1;
  localparam int SW   = $clog2(3 * NGRP);

  state_t              state_q, state_d;
  logic [Bits-1:0]     m_q, m_d;
  logic [Bits-1:0]     q_q, q_d;
  logic [MW-1:0]       m3_q, m3_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [KW-1:0]       k_q, k_d;
  logic [2*Bits-1:0]   z_q, z_d;

  logic [QW-1:0]       q_ext;
  logic [SW-1:0]       shamt;
  logic [3:0]          grp;
  sel_t                sel;
  logic                neg;
  logic [MW-1:0]       mag;
  logic [AW-1:0]       pp;
  logic [AW-1:0]       acc_sum;
  logic                ready_int;
  logic                accept;

  // Q with the implicit q[-1]=0 below and zero padding above.
  assign q_ext = QW'({q_q, 1'b0});
  assign shamt = SW'(k_q) + SW'({k_q, 1'b0});
  assign grp   = q_ext[shamt +: 4];

  booth8_digit_enc u_enc (
    .grp_i (grp),
    .sel_o (sel),
    .neg_o (neg)
  );

  always_comb begin
    mag = '0;
    case (sel)
      SEL_1M:  mag = {2'b00, m_q};
      SEL_2M:  mag = {1'b0, m_q, 1'b0};
      SEL_3M:  mag = m3_q;
      SEL_4M:  mag = {m_q, 2'b00};
      default: mag = '0;
    endcase
  end

  // Negation as inverse plus a carry-in at the group's weight 2^(3k).
  assign pp      = neg ? ~AW'(mag) : AW'(mag);
  assign acc_sum = acc_q + (pp << shamt) + (AW'(neg) << shamt);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      m3_q    <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      m3_q    <= m3_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    m3_d      = m3_q;
    acc_d     = acc_q;
    k_d       = k_q;
    z_d       = z_q;
    ready_int = 1'b0;
    oValid    = 1'b0;
    oBusy     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_int = 1'b1;
        accept    = iValid;
      end
      PRE: begin
        oBusy   = 1'b1;
        m3_d    = {2'b00, m_q} + {1'b0, m_q, 1'b0};
        state_d = ACC;
      end
      ACC: begin
        oBusy = 1'b1;
        acc_d = acc_sum;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NGRP - 1)) begin
          state_d = DONE;
          z_d     = acc_sum[2*Bits-1:0];
        end
      end
      DONE: begin
        oValid    = 1'b1;
        ready_int = iReady;
        if (iReady) begin
          accept  = iValid;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      m_d     = iM;
      q_d     = iQ;
      acc_d   = '0;
      k_d     = '0;
      state_d = PRE;
    end
  end

  assign oReady = ready_int & ~iRst;
  assign oZ     = z_q;

endmodule

// File: tb/tb_booth8_seq_ctrl.sv
// Directed bench for booth8_seq_ctrl: latency, products, backpressure,
// back-to-back handoff and asynchronous abort.
module tb_booth8_seq_ctrl;

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [15:0] iM;
  logic [15:0] iQ;
  logic        oValid;
  logic        iReady;
  logic [31:0] oZ;
  logic        oBusy;

  int errors = 0;
  int checks = 0;

  booth8_seq_ctrl #(.Bits(16)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iM     (iM),
    .iQ     (iQ),
    .oValid (oValid),
    .iReady (iReady),
    .oZ     (oZ),
    .oBusy  (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Present operands in IDLE or DONE and take the accept edge E0.
  task automatic start(input logic [15:0] m, input logic [15:0] q);
    iM     = m;
    iQ     = q;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    iM     = 16'h5A5A;
    iQ     = 16'hA5A5;
    chk("busy_after_accept", 64'(oBusy), 64'd1);
    chk("ready_low_after_accept", 64'(oReady), 64'd0);
  endtask

  // Edges E1..E6 show no valid; E7 presents the product.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk({tag, "_no_early_valid"}, 64'(oValid), 64'd0);
    end
    step();
    chk({tag, "_valid_e7"}, 64'(oValid), 64'd1);
    chk({tag, "_z"}, 64'(oZ), 64'(exp));
    chk({tag, "_busy_done"}, 64'(oBusy), 64'd0);
  endtask

  task automatic handoff_to_idle(input string tag);
    iReady = 1'b1;
    iValid = 1'b0;
    step();
    chk({tag, "_valid_drop"}, 64'(oValid), 64'd0);
    chk({tag, "_ready_idle"}, 64'(oReady), 64'd1);
  endtask

  initial begin
    iRst   = 1'b1;
    iValid = 1'b0;
    iReady = 1'b1;
    iM     = '0;
    iQ     = '0;
    #1;
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_z", 64'(oZ), 64'd0);
    step();
    step();
    iRst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(oReady), 64'd1);

    start(16'h0003, 16'h0005);
    wait_done("m3x5", 32'h0000_000F);
    handoff_to_idle("m3x5");

    start(16'hFFFF, 16'hFFFF);
    wait_done("mffff", 32'hFFFE_0001);
    handoff_to_idle("mffff");

    start(16'h00FF, 16'h0100);
    wait_done("mff_100", 32'h0000_FF00);
    handoff_to_idle("mff_100");
    chk("z_retained_idle", 64'(oZ), 64'h0000_FF00);

    start(16'hABCD, 16'h0000);
    chk("z_retained_busy", 64'(oZ), 64'h0000_FF00);
    wait_done("q_zero", 32'h0);
    handoff_to_idle("q_zero");

    start(16'h0000, 16'hFFFF);
    wait_done("m_zero", 32'h0);
    handoff_to_idle("m_zero");

    start(16'h1111, 16'h0003);
    wait_done("m3sel", 32'h0000_3333);
    handoff_to_idle("m3sel");

    // Backpressure: consumer stalls five cycles while producer pokes iValid.
    iReady = 1'b0;
    start(16'h1234, 16'h0010);
    wait_done("bp", 32'h0001_2340);
    for (int i = 0; i < 5; i++) begin
      iValid = (i % 2 == 0);
      iM     = 16'h0001;
      iQ     = 16'h0001;
      #1;
      chk("bp_ready_low", 64'(oReady), 64'd0);
      step();
      chk("bp_valid_hold", 64'(oValid), 64'd1);
      chk("bp_z_hold", 64'(oZ), 64'h0001_2340);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    #1;
    chk("bp_ready_follows", 64'(oReady), 64'd1);
    step();
    chk("bp_handoff_valid", 64'(oValid), 64'd0);
    chk("bp_handoff_idle_ready", 64'(oReady), 64'd1);
    chk("bp_z_after", 64'(oZ), 64'h0001_2340);

    // Back-to-back: second operands accepted in the DONE cycle.
    start(16'h0007, 16'h0009);
    wait_done("b2b_first", 32'h0000_003F);
    start(16'h0010, 16'h0010);
    chk("b2b_valid_drop", 64'(oValid), 64'd0);
    wait_done("b2b_second", 32'h0000_0100);
    handoff_to_idle("b2b_second");

    // Abort during ACC with k=3 (after edge E4).
    start(16'h00FF, 16'h00FF);
    step();
    step();
    step();
    step();
    chk("abort_pre_busy", 64'(oBusy), 64'd1);
    iRst = 1'b1;
    #1;
    chk("abort_busy", 64'(oBusy), 64'd0);
    chk("abort_valid", 64'(oValid), 64'd0);
    chk("abort_z", 64'(oZ), 64'd0);
    step();
    iRst = 1'b0;
    #1;
    chk("abort_release_ready", 64'(oReady), 64'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_no_stale_valid", 64'(oValid), 64'd0);
    end
    chk("abort_idle_busy", 64'(oBusy), 64'd0);

    start(16'h1111, 16'h0003);
    wait_done("post_abort", 32'h0000_3333);
    handoff_to_idle("post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
